ialu_req_issuer: RTL and testbench
==================================

IALU_REQ_ISSUER -- requirements
Module: ialu_req_issuer

Interface
REQ-001 XLEN, default `SCR1_XLEN (32), operand/result width.
REQ-002 TIMEOUT_CYC, default 40, maximum cycles to wait for ialu_rvm_res_rdy_i; range 2..255.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_vd  in  1  upstream request valid.
REQ-006 in_rdy  out  1  upstream request accepted when in_vd & in_rdy.
REQ-007 in_cmd  in  CMD_W  IALU command, type_scr1_ialu_cmd_sel_e encoding.
REQ-008 in_op1  in  XLEN  main operand 1.
REQ-009 in_op2  in  XLEN  main operand 2.
REQ-010 out_vd  out  1  response valid.
REQ-011 out_rdy  in  1  response consumed when out_vd & out_rdy.
REQ-012 out_res  out  XLEN  captured ialu_main_res_i.
REQ-013 out_cmp  out  1  captured ialu_cmp_res_i.
REQ-014 out_err  out  1  response is a timeout, out_res = 0.
REQ-015 ialu_rvm_cmd_vd_o  out  1  mul/div request to IALU.
REQ-016 ialu_cmd_o  out  CMD_W  command to IALU.
REQ-017 ialu_main_op1_o  out  XLEN  operand 1 to IALU.
REQ-018 ialu_main_op2_o  out  XLEN  operand 2 to IALU.
REQ-019 ialu_main_res_i  in  XLEN  IALU main result.
REQ-020 ialu_cmp_res_i  in  1  IALU compare result.
REQ-021 ialu_rvm_res_rdy_i  in  1  IALU mul/div result valid, one-cycle pulse.

Function
REQ-022 FSM states: IDLE, EXEC, RESP; one request in flight; in_rdy = 1 only in IDLE.
REQ-023 IDLE: on in_vd & in_rdy, register cmd/op1/op2 into ialu_*_o and go to EXEC next cycle.
REQ-024 ialu_cmd_o and ialu_main_op*_o stay constant from EXEC entry until EXEC exit; both are zero outside EXEC/RESP.
REQ-025 EXEC, non-RVM cmd: ialu_rvm_cmd_vd_o = 0; capture main_res/cmp_res in the first EXEC cycle and go to RESP; out_vd rises 2 cycles after the accept.
REQ-026 EXEC, RVM cmd (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU): ialu_rvm_cmd_vd_o = 1 for every EXEC cycle; capture results in the cycle in which ialu_rvm_res_rdy_i = 1 and go to RESP; ialu_rvm_cmd_vd_o = 0 the following cycle.
REQ-027 8-bit wait counter clears on EXEC entry and increments on each RVM EXEC cycle with res_rdy = 0; reaching TIMEOUT_CYC sends FSM to RESP with out_err = 1, out_res = 0, out_cmp = 0, and drops ialu_rvm_cmd_vd_o.
REQ-028 If res_rdy and the timeout occur in the same cycle, res_rdy wins and out_err = 0.
REQ-029 RESP: out_vd = 1; out_res/out_cmp/out_err are stable until out_vd & out_rdy, then go to IDLE; the next accept is possible the cycle after.
REQ-030 ialu_rvm_res_rdy_i outside RVM EXEC is ignored and has no state effect.

Reset
REQ-031 rst_n = 0 at any clock edge forces IDLE, counter = 0, and all outputs = 0 except in_rdy (1 after reset release); an in-flight request is discarded without a response.
REQ-032 After reset release, ialu_rvm_cmd_vd_o stays 0 until a new RVM request reaches EXEC.

Structure
REQ-033 CMD_W, the RVM command set and an is_rvm_cmd() function reside in a shared package beside scr1_riscv_isa_decoding; the FSM state enum is also defined there.
REQ-034 No sub-module; the IALU address-adder inputs are tied to zero at the integration top.

Verification
REQ-035 ADD 5, 7, out_rdy = 1 -> out_vd at accept+2, out_res = 12, out_err = 0.
REQ-036 DIV 100, 7, responder pulses res_rdy 32 cycles into EXEC -> out_res = 14 the next cycle; rvm_cmd_vd high exactly 33 cycles.
REQ-037 SLT 3, 9 with out_rdy held low 4 cycles -> out_vd, out_res and out_cmp = 1 stable for all 4 cycles; in_rdy = 0 throughout.
REQ-038 MUL with res_rdy never pulsed, TIMEOUT_CYC = 40 -> out_err = 1 and out_res = 0 after 40 EXEC cycles; rvm_cmd_vd = 0 in RESP.
REQ-039 rst_n low for 1 cycle mid-DIV -> IDLE, no response; the following ADD 1, 1 returns 2.
REQ-040 Back-to-back MULHU 0xFFFFFFFF, 0xFFFFFFFF then SUB 0, 1 -> 0xFFFFFFFE then 0xFFFFFFFF, in order, with no lost request.

Source files
------------

// File: rtl/ialu_req_issuer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ialu_req_issuer_pkg
// Description : Shared types for the IALU request issuer. Holds the IALU
//               command encoding, the set of mul/div (RVM) commands with
//               the is_rvm_cmd() helper, and the issuer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package ialu_req_issuer_pkg;

    // Width of the IALU command field.
    localparam int CMD_W = 5;

    // IALU command encoding (SCR1 ordering; mul/div group at the top).
    typedef enum logic [CMD_W-1:0] {
        SCR1_IALU_CMD_NONE    = 5'd0,
        SCR1_IALU_CMD_AND     = 5'd1,
        SCR1_IALU_CMD_OR      = 5'd2,
        SCR1_IALU_CMD_XOR     = 5'd3,
        SCR1_IALU_CMD_ADD     = 5'd4,
        SCR1_IALU_CMD_SUB     = 5'd5,
        SCR1_IALU_CMD_SUB_LT  = 5'd6,
        SCR1_IALU_CMD_SUB_LTU = 5'd7,
        SCR1_IALU_CMD_SUB_EQ  = 5'd8,
        SCR1_IALU_CMD_SUB_NE  = 5'd9,
        SCR1_IALU_CMD_SUB_GE  = 5'd10,
        SCR1_IALU_CMD_SUB_GEU = 5'd11,
        SCR1_IALU_CMD_SLL     = 5'd12,
        SCR1_IALU_CMD_SRL     = 5'd13,
        SCR1_IALU_CMD_SRA     = 5'd14,
        SCR1_IALU_CMD_MUL     = 5'd15,
        SCR1_IALU_CMD_MULHU   = 5'd16,
        SCR1_IALU_CMD_MULHSU  = 5'd17,
        SCR1_IALU_CMD_MULH    = 5'd18,
        SCR1_IALU_CMD_DIV     = 5'd19,
        SCR1_IALU_CMD_DIVU    = 5'd20,
        SCR1_IALU_CMD_REM     = 5'd21,
        SCR1_IALU_CMD_REMU    = 5'd22
    } type_scr1_ialu_cmd_sel_e;

    // Issuer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } type_issuer_state_e;

    // True for commands executed by the multi-cycle mul/div unit, which
    // need the request-valid/result-ready handshake.
    function automatic logic is_rvm_cmd(input type_scr1_ialu_cmd_sel_e cmd);
        logic r;
        case (cmd)
            SCR1_IALU_CMD_MUL,
            SCR1_IALU_CMD_MULH,
            SCR1_IALU_CMD_MULHSU,
            SCR1_IALU_CMD_MULHU,
            SCR1_IALU_CMD_DIV,
            SCR1_IALU_CMD_DIVU,
            SCR1_IALU_CMD_REM,
            SCR1_IALU_CMD_REMU:  r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ialu_req_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : ialu_req_issuer_if
// Description : Bundle of all issuer handshake/bus signals.
//               Upstream request : in_vd, in_rdy, in_cmd, in_op1, in_op2
//               Response         : out_vd, out_rdy, out_res, out_cmp, out_err
//               IALU side        : ialu_rvm_cmd_vd_o, ialu_cmd_o,
//                                  ialu_main_op1_o, ialu_main_op2_o,
//                                  ialu_main_res_i, ialu_cmp_res_i,
//                                  ialu_rvm_res_rdy_i
//               Modport slave is taken by the issuer; master by its
//               environment (requester, response sink and IALU).
// Revision    : 1.0 - initial release
// ============================================================================
interface ialu_req_issuer_if
    import ialu_req_issuer_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                    in_vd;
    logic                    in_rdy;
    type_scr1_ialu_cmd_sel_e in_cmd;
    logic [XLEN-1:0]         in_op1;
    logic [XLEN-1:0]         in_op2;

    logic                    out_vd;
    logic                    out_rdy;
    logic [XLEN-1:0]         out_res;
    logic                    out_cmp;
    logic                    out_err;

    logic                    ialu_rvm_cmd_vd_o;
    type_scr1_ialu_cmd_sel_e ialu_cmd_o;
    logic [XLEN-1:0]         ialu_main_op1_o;
    logic [XLEN-1:0]         ialu_main_op2_o;
    logic [XLEN-1:0]         ialu_main_res_i;
    logic                    ialu_cmp_res_i;
    logic                    ialu_rvm_res_rdy_i;

    modport slave (
        input  in_vd, in_cmd, in_op1, in_op2, out_rdy,
               ialu_main_res_i, ialu_cmp_res_i, ialu_rvm_res_rdy_i,
        output in_rdy, out_vd, out_res, out_cmp, out_err,
               ialu_rvm_cmd_vd_o, ialu_cmd_o, ialu_main_op1_o, ialu_main_op2_o
    );

    modport master (
        output in_vd, in_cmd, in_op1, in_op2, out_rdy,
               ialu_main_res_i, ialu_cmp_res_i, ialu_rvm_res_rdy_i,
        input  in_rdy, out_vd, out_res, out_cmp, out_err,
               ialu_rvm_cmd_vd_o, ialu_cmd_o, ialu_main_op1_o, ialu_main_op2_o
    );

endinterface
`default_nettype wire

// File: rtl/ialu_req_issuer.sv
`default_nettype none
// ============================================================================
// Module      : ialu_req_issuer
// Description : Issues one IALU operation at a time. A request accepted in
//               IDLE is registered onto the IALU command/operand lines and
//               held through EXEC. Plain ALU commands complete in a single
//               EXEC cycle; mul/div commands assert ialu_rvm_cmd_vd_o until
//               ialu_rvm_res_rdy_i pulses or TIMEOUT_CYC EXEC cycles elapse
//               (timeout response: out_err=1, out_res=0, out_cmp=0). The
//               result is held in RESP until out_vd & out_rdy.
// Ports       : clk     - clock, rising edge
//               rst_n   - synchronous active-low reset
//               io_bus  - ialu_req_issuer_if.slave (request, response, IALU)
// Parameters  : XLEN        - operand/result width (must match io_bus)
//               TIMEOUT_CYC - mul/div wait limit in cycles, 2..255
// Revision    : 1.0 - initial release
// ============================================================================
module ialu_req_issuer
    import ialu_req_issuer_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 40
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    ialu_req_issuer_if.slave   io_bus
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYC);

    type_issuer_state_e      r_state;
    type_issuer_state_e      w_state_nxt;

    type_scr1_ialu_cmd_sel_e r_cmd;
    logic [XLEN-1:0]         r_op1;
    logic [XLEN-1:0]         r_op2;
    logic [XLEN-1:0]         r_res;
    logic                    r_cmp;
    logic                    r_err;
    logic [7:0]              r_wait_cnt;

    logic                    w_in_rdy;
    logic                    w_out_vd;
    logic                    w_rvm_vd;
    logic                    w_accept;
    logic                    w_resp_hs;
    logic                    w_exec;
    logic                    w_rvm;
    logic                    w_capture;
    logic                    w_timeout;
    logic                    w_wait;
    logic [7:0]              w_cnt_inc;

    assign w_accept  = (r_state == ST_IDLE) && io_bus.in_vd;
    assign w_resp_hs = (r_state == ST_RESP) && io_bus.out_rdy;
    assign w_exec    = (r_state == ST_EXEC);
    assign w_rvm     = is_rvm_cmd(r_cmd);

    // Plain commands capture on the first EXEC cycle; mul/div commands
    // capture only on the result-ready pulse, so res_rdy in any other
    // state or for a plain command has no effect.
    assign w_capture = w_exec && (!w_rvm || io_bus.ialu_rvm_res_rdy_i);
    assign w_wait    = w_exec &&  w_rvm && !io_bus.ialu_rvm_res_rdy_i;
    assign w_cnt_inc = r_wait_cnt + 8'd1;
    // The timeout is only taken on a waiting cycle, so a result arriving
    // on the final allowed cycle takes priority over the error.
    assign w_timeout = w_wait && (w_cnt_inc == c_TIMEOUT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_rdy    = 1'b0;
        w_out_vd    = 1'b0;
        w_rvm_vd    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_rdy = 1'b1;
                if (io_bus.in_vd) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_rvm_vd = w_rvm;
                if (w_capture || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_out_vd = 1'b1;
                if (io_bus.out_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command/operand hold, wait counter and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd      <= SCR1_IALU_CMD_NONE;
            r_op1      <= '0;
            r_op2      <= '0;
            r_res      <= '0;
            r_cmp      <= 1'b0;
            r_err      <= 1'b0;
            r_wait_cnt <= 8'd0;
        end else begin
            if (w_accept) begin
                r_cmd      <= io_bus.in_cmd;
                r_op1      <= io_bus.in_op1;
                r_op2      <= io_bus.in_op2;
                r_wait_cnt <= 8'd0;
            end else if (w_resp_hs) begin
                // Return the IALU lines and response fields to zero so
                // nothing stale is presented while idle.
                r_cmd <= SCR1_IALU_CMD_NONE;
                r_op1 <= '0;
                r_op2 <= '0;
                r_res <= '0;
                r_cmp <= 1'b0;
                r_err <= 1'b0;
            end

            if (w_wait) begin
                r_wait_cnt <= w_cnt_inc;
            end

            if (w_capture) begin
                r_res <= io_bus.ialu_main_res_i;
                r_cmp <= io_bus.ialu_cmp_res_i;
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_res <= '0;
                r_cmp <= 1'b0;
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign io_bus.in_rdy            = w_in_rdy;
    assign io_bus.out_vd            = w_out_vd;
    assign io_bus.out_res           = r_res;
    assign io_bus.out_cmp           = r_cmp;
    assign io_bus.out_err           = r_err;
    assign io_bus.ialu_rvm_cmd_vd_o = w_rvm_vd;
    assign io_bus.ialu_cmd_o        = r_cmd;
    assign io_bus.ialu_main_op1_o   = r_op1;
    assign io_bus.ialu_main_op2_o   = r_op2;

endmodule
`default_nettype wire

// File: tb/tb_ialu_req_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ialu_req_issuer
// Description : Self-checking bench for ialu_req_issuer. A transaction-level
//               model predicts, from each accepted request and the chosen
//               IALU result delay, the cycles of EXEC/RESP and the response
//               contents; a per-cycle compare process checks the DUT
//               against it. Directed requests also carry hand-computed
//               literal results, latencies and request-valid cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ialu_req_issuer;
    import ialu_req_issuer_pkg::*;

    localparam int c_TIMEOUT = 40;
    localparam int c_NEVER   = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    // IALU responder controls
    int   rdy_delay  = c_NEVER;  // EXEC cycles before the res_rdy pulse
    int   run_before = 0;        // consecutive prior cycles of rvm_cmd_vd
    logic rr_force   = 1'b0;     // stray res_rdy injection
    int   vd_cnt     = 0;

    ialu_req_issuer_if #(.XLEN(32)) bus ();

    ialu_req_issuer #(
        .XLEN        (32),
        .TIMEOUT_CYC (c_TIMEOUT)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic: {cmp, res} ----------------
    function automatic logic [32:0] ref_alu(input type_scr1_ialu_cmd_sel_e c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        logic        lt;
        p  = {32'd0, a} * {32'd0, b};
        lt = ($signed(a) < $signed(b));
        case (c)
            SCR1_IALU_CMD_ADD:    return {1'b0, a + b};
            SCR1_IALU_CMD_SUB:    return {1'b0, a - b};
            SCR1_IALU_CMD_SUB_LT: return {lt, 31'd0, lt};
            SCR1_IALU_CMD_MUL:    return {1'b0, p[31:0]};
            SCR1_IALU_CMD_MULHU:  return {1'b0, p[63:32]};
            SCR1_IALU_CMD_DIV:    return {1'b0, 32'($signed(a) / $signed(b))};
            SCR1_IALU_CMD_REMU:   return {1'b0, a % b};
            default:              return 33'd0;
        endcase
    endfunction

    function automatic bit tb_is_muldiv(input type_scr1_ialu_cmd_sel_e c);
        return (c == SCR1_IALU_CMD_MUL)  || (c == SCR1_IALU_CMD_MULH)  ||
               (c == SCR1_IALU_CMD_MULHSU) || (c == SCR1_IALU_CMD_MULHU) ||
               (c == SCR1_IALU_CMD_DIV)  || (c == SCR1_IALU_CMD_DIVU)  ||
               (c == SCR1_IALU_CMD_REM)  || (c == SCR1_IALU_CMD_REMU);
    endfunction

    // ---------------- IALU stub ----------------
    assign {bus.ialu_cmp_res_i, bus.ialu_main_res_i} =
        ref_alu(bus.ialu_cmd_o, bus.ialu_main_op1_o, bus.ialu_main_op2_o);
    assign bus.ialu_rvm_res_rdy_i = rr_force |
        (bus.ialu_rvm_cmd_vd_o && (run_before == rdy_delay));
    always @(posedge clk) run_before <= bus.ialu_rvm_cmd_vd_o ? run_before + 1 : 0;
    always @(negedge clk) if (bus.ialu_rvm_cmd_vd_o) vd_cnt <= vd_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model + per-cycle compare ----------------
    bit                      m_busy = 1'b0;
    bit                      m_rvm, m_err, m_cmp;
    int                      m_tacc, m_e;
    type_scr1_ialu_cmd_sel_e m_cmd;
    logic [31:0]             m_op1, m_op2, m_res;
    bit                      c_ex, c_rsp;

    always @(negedge clk) begin
        c_ex  = m_busy && (cyc > m_tacc) && (cyc <= m_tacc + m_e);
        c_rsp = m_busy && (cyc > m_tacc + m_e);
        if (chk_en) begin
            chk("in_rdy",     32'(bus.in_rdy),            32'(!m_busy));
            chk("out_vd",     32'(bus.out_vd),            32'(c_rsp));
            chk("rvm_cmd_vd", 32'(bus.ialu_rvm_cmd_vd_o), 32'(c_ex && m_rvm));
            chk("ialu_cmd",   32'(bus.ialu_cmd_o),
                m_busy ? 32'(m_cmd) : 32'd0);
            chk("ialu_op1",   bus.ialu_main_op1_o,        m_busy ? m_op1 : 32'd0);
            chk("ialu_op2",   bus.ialu_main_op2_o,        m_busy ? m_op2 : 32'd0);
            if (c_rsp) begin
                chk("out_res", bus.out_res,          m_res);
                chk("out_cmp", 32'(bus.out_cmp),     32'(m_cmp));
                chk("out_err", 32'(bus.out_err),     32'(m_err));
            end
        end
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (!m_busy && bus.in_vd) begin
            m_busy = 1'b1;
            m_tacc = cyc;
            m_cmd  = bus.in_cmd;
            m_op1  = bus.in_op1;
            m_op2  = bus.in_op2;
            m_rvm  = tb_is_muldiv(bus.in_cmd);
            m_err  = m_rvm && (rdy_delay + 1 > c_TIMEOUT);
            m_e    = !m_rvm ? 1 : (m_err ? c_TIMEOUT : rdy_delay + 1);
            {m_cmp, m_res} = m_err ? 33'd0 : ref_alu(bus.in_cmd, bus.in_op1, bus.in_op2);
        end else if (c_rsp && bus.out_rdy) begin
            m_busy = 1'b0;
        end
    end

    // ---------------- driver ----------------
    // Entered and left just after a rising edge.
    task automatic do_req(input type_scr1_ialu_cmd_sel_e cmd,
                          input logic [31:0] a, input logic [31:0] b,
                          input int dly, input int hold,
                          input logic [31:0] e_res, input bit e_cmp, input bit e_err,
                          input int e_lat, input int e_vd);
        int t_acc, k, v0;
        v0         = vd_cnt;
        rdy_delay  = dly;
        bus.in_vd  = 1'b1;
        bus.in_cmd = cmd;
        bus.in_op1 = a;
        bus.in_op2 = b;
        bus.out_rdy = (hold == 0);
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.in_rdy && k < 50);
        chk("accept", 32'(bus.in_rdy), 32'd1);
        t_acc = cyc;
        @(posedge clk); #1;
        bus.in_vd  = 1'b0;
        bus.in_cmd = SCR1_IALU_CMD_AND;
        bus.in_op1 = 32'hDEADBEEF;
        bus.in_op2 = 32'hCAFEF00D;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.out_vd && k < 300);
        chk("resp_seen", 32'(bus.out_vd), 32'd1);
        chk("latency",   32'(cyc - t_acc), 32'(e_lat));
        chk("lit_res",   bus.out_res, e_res);
        chk("lit_cmp",   32'(bus.out_cmp), 32'(e_cmp));
        chk("lit_err",   32'(bus.out_err), 32'(e_err));
        chk("vd_cycles", 32'(vd_cnt - v0), 32'(e_vd));
        if (hold > 0) begin
            repeat (hold - 1) @(negedge clk);
            chk("hold_vd",  32'(bus.out_vd), 32'd1);
            chk("hold_res", bus.out_res, e_res);
            chk("hold_cmp", 32'(bus.out_cmp), 32'(e_cmp));
            chk("hold_rdy", 32'(bus.in_rdy), 32'd0);
            @(posedge clk); #1;
            bus.out_rdy = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_vd   = 1'b0;
        bus.in_cmd  = SCR1_IALU_CMD_NONE;
        bus.in_op1  = 32'd0;
        bus.in_op2  = 32'd0;
        bus.out_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy",  32'(bus.in_rdy), 32'd1);
        chk("rst_out_vd",  32'(bus.out_vd), 32'd0);
        chk("rst_out_res", bus.out_res, 32'd0);
        chk("rst_out_err", 32'(bus.out_err), 32'd0);
        chk("rst_rvm_vd",  32'(bus.ialu_rvm_cmd_vd_o), 32'd0);
        chk("rst_cmd",     32'(bus.ialu_cmd_o), 32'd0);
        chk("rst_op1",     bus.ialu_main_op1_o, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // cmd, op1, op2, delay, hold, res, cmp, err, latency, rvm_vd cycles
        do_req(SCR1_IALU_CMD_ADD,    32'd5,   32'd7, c_NEVER, 0, 32'd12, 1'b0, 1'b0, 2, 0);
        do_req(SCR1_IALU_CMD_DIV,    32'd100, 32'd7, 32,      0, 32'd14, 1'b0, 1'b0, 34, 33);
        do_req(SCR1_IALU_CMD_SUB_LT, 32'd3,   32'd9, c_NEVER, 4, 32'd1,  1'b1, 1'b0, 2, 0);
        do_req(SCR1_IALU_CMD_MUL,    32'd3,   32'd4, c_NEVER, 0, 32'd0,  1'b0, 1'b1, 41, 40);
        // Result on the very cycle the timeout would fire
        do_req(SCR1_IALU_CMD_MUL,    32'd6,   32'd7, 39,      0, 32'd42, 1'b0, 1'b0, 41, 40);
        // Result on the first EXEC cycle
        do_req(SCR1_IALU_CMD_REMU,   32'd100, 32'd7, 0,       0, 32'd2,  1'b0, 1'b0, 2, 1);

        // Stray res_rdy in IDLE and during a plain command
        rr_force = 1'b1;
        @(posedge clk); #1;
        do_req(SCR1_IALU_CMD_ADD, 32'h7FFFFFFF, 32'd1, c_NEVER, 0, 32'h80000000, 1'b0, 1'b0, 2, 0);
        rr_force = 1'b0;

        // Reset in the middle of a DIV
        rdy_delay  = c_NEVER;
        bus.in_vd  = 1'b1;
        bus.in_cmd = SCR1_IALU_CMD_DIV;
        bus.in_op1 = 32'd50;
        bus.in_op2 = 32'd5;
        @(posedge clk); #1;
        bus.in_vd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_out_vd", 32'(bus.out_vd), 32'd0);
            chk("post_rst_rvm_vd", 32'(bus.ialu_rvm_cmd_vd_o), 32'd0);
            chk("post_rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        end
        @(posedge clk); #1;
        do_req(SCR1_IALU_CMD_ADD, 32'd1, 32'd1, c_NEVER, 0, 32'd2, 1'b0, 1'b0, 2, 0);

        // Back-to-back requests
        do_req(SCR1_IALU_CMD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 0, 32'hFFFFFFFE, 1'b0, 1'b0, 5, 4);
        do_req(SCR1_IALU_CMD_SUB,   32'd0, 32'd1, c_NEVER, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
